// File: rtl/smult_arbiter.sv
// Round-robin arbiter sharing one registered signed multiplier between two requesters.
// Operands are held on the multiplier during a response stall, so mult_result is the response.
module smult_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [2*N-1:0] resp_result,
    output logic [N-1:0]   mult_a,
    output logic [N-1:0]   mult_b,
    input  logic [2*N-1:0] mult_result
);

    logic         prio_q, prio_d;
    logic         rv_q, rv_d;
    logic         rid_q, rid_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;

    logic         take;
    logic         can_accept;
    logic         gnt_any;
    logic         gnt_id;
    logic         accept;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;

    always_comb begin
        take       = rv_q && (rid_q ? resp1_ready : resp0_ready);
        can_accept = !rst && (!rv_q || take);
        gnt_any    = req0_valid || req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = can_accept && gnt_any && !gnt_id;
        req1_ready = can_accept && gnt_any && gnt_id;
        // The granted requester is always valid, so a grant inside the window is an accept.
        accept     = can_accept && gnt_any;
        sel_a      = gnt_id ? req1_a : req0_a;
        sel_b      = gnt_id ? req1_b : req0_b;

        prio_d = prio_q;
        rv_d   = rv_q;
        rid_d  = rid_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (accept) begin
            op_a_d = sel_a;
            op_b_d = sel_b;
            rid_d  = gnt_id;
            rv_d   = 1'b1;
            prio_d = !gnt_id;
        end else if (take) begin
            rv_d = 1'b0;
        end

        if (rst) begin
            mult_a = '0;
            mult_b = '0;
        end else if (accept) begin
            mult_a = sel_a;
            mult_b = sel_b;
        end else begin
            mult_a = op_a_q;
            mult_b = op_b_q;
        end

        resp_result = mult_result;
        resp0_valid = rv_q && !rid_q;
        resp1_valid = rv_q && rid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
            rv_q   <= 1'b0;
            rid_q  <= 1'b0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            prio_q <= prio_d;
            rv_q   <= rv_d;
            rid_q  <= rid_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
        end
    end

endmodule

// File: tb/tb_smult_arbiter.sv
// Scoreboard bench for smult_arbiter: directed cases, then randomized traffic and back-pressure.
module tb_smult_arbiter;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [2*N-1:0] resp_result;
    logic [N-1:0]   mult_a, mult_b;
    logic [2*N-1:0] mult_result = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic           id;
        logic [2*N-1:0] prod;
    } exp_t;
    exp_t exp_q[$];

    smult_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result),
        .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] prod(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return p;
    endfunction

    // Stand-in for the attached sync_smult: one registered cycle of latency.
    always @(posedge clk) mult_result <= prod(mult_a, mult_b);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor / reference model state
    logic           rst_prev = 1'b0;
    logic           last_id = 1'b1;
    logic [N-1:0]   last_a = '0, last_b = '0;
    logic           prev_acc = 1'b0, prev_id = 1'b0;
    logic           prev_stall = 1'b0;
    logic [2*N+1:0] prev_snap = '0;
    logic           acc0_seen = 1'b0, acc1_seen = 1'b0;

    always @(negedge clk) begin
        logic pend, taken, want, gid, acc;
        logic [1:0] exp_rdy;
        logic [N-1:0] ea, eb;
        exp_t e;
        acc0_seen = 1'b0;
        acc1_seen = 1'b0;
        if (rst) begin
            chk("reset_ready", {req0_ready, req1_ready}, 2'b00);
            chk("reset_mult", {mult_a, mult_b}, '0);
            exp_q.delete();
            last_id = 1'b1;
            last_a = '0;
            last_b = '0;
            prev_acc = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (rst_prev) chk("post_reset_resp", {resp0_valid, resp1_valid, resp_result}, '0);
            if (prev_acc) chk("latency", {resp0_valid, resp1_valid}, prev_id ? 2'b01 : 2'b10);
            if (prev_stall) chk("stall_hold", {resp0_valid, resp1_valid, resp_result}, prev_snap);

            pend  = resp0_valid || resp1_valid;
            taken = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
            want  = (!pend || taken) && (req0_valid || req1_valid);
            gid   = (req0_valid && req1_valid) ? !last_id : req1_valid;
            exp_rdy = want ? (gid ? 2'b01 : 2'b10) : 2'b00;
            chk("grant", {req0_ready, req1_ready}, exp_rdy);

            if (taken) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_id", resp1_valid, e.id);
                    chk("resp_result", resp_result, e.prod);
                end
            end

            acc = (req0_valid && req0_ready) || (req1_valid && req1_ready);
            gid = req1_valid && req1_ready;
            ea  = acc ? (gid ? req1_a : req0_a) : last_a;
            eb  = acc ? (gid ? req1_b : req0_b) : last_b;
            chk("mult_drive", {mult_a, mult_b}, {ea, eb});
            if (acc) begin
                e.id = gid;
                e.prod = prod(ea, eb);
                exp_q.push_back(e);
                last_id = gid;
                last_a = ea;
                last_b = eb;
                acc0_seen = !gid;
                acc1_seen = gid;
            end
            prev_acc   = acc;
            prev_id    = gid;
            prev_stall = pend && !taken;
            prev_snap  = {resp0_valid, resp1_valid, resp_result};
        end
        rst_prev = rst;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input int a, input int b);
        logic got;
        got = 1'b0;
        if (id == 0) begin req0_valid = 1'b1; req0_a = a[N-1:0]; req0_b = b[N-1:0]; end
        else         begin req1_valid = 1'b1; req1_a = a[N-1:0]; req1_b = b[N-1:0]; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (id == 0) ? req0_ready : req1_ready;
        end
        chk("accept_wait", got, 1'b1);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 5, 4);
        issue(1, 5, -3);
        issue(1, -2, -3);
        issue(0, -128, -128);
        issue(1, -2, 0);
        repeat (2) next_cycle();

        // Contention from reset
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd3;
        req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd7;
        next_cycle();
        rst = 1'b0;
        repeat (6) next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) next_cycle();

        // Back-pressure
        resp0_ready = 1'b0;
        issue(0, 6, -7);
        req1_valid = 1'b1; req1_a = 8'd4; req1_b = 8'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_result", resp_result, 16'hFFD6);
            chk("bp_req1_ready", req1_ready, 1'b0);
            next_cycle();
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", req1_ready, 1'b1);
        next_cycle();
        req1_valid = 1'b0;
        repeat (2) next_cycle();

        // Reset mid-flight
        resp0_ready = 1'b0;
        issue(0, 9, 9);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        resp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2;
        req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4;
        @(negedge clk);
        chk("post_reset_first_grant", {req0_ready, req1_ready}, 2'b10);
        repeat (3) next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) next_cycle();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!req0_valid || acc0_seen) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_a = N'($urandom);
                req0_b = N'($urandom);
            end
            if (!req1_valid || acc1_seen) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_a = N'($urandom);
                req1_b = N'($urandom);
            end
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (4) next_cycle();
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smult_arbiter.md
# smult_arbiter

Round-robin arbiter that shares one `sync_smult` signed multiplier (1-cycle registered latency) between two requesters in the pico MIPS datapath. It accepts operand pairs over valid/ready handshakes and drives the multiplier inputs. It returns each product to the requester that issued it, with response back-pressure. Full throughput is one multiply per cycle.

## Interface
- `N`, default 8: operand width. Products are 2N bits. Must match the attached `sync_smult #(.N(N))`.

Clock and reset:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.

Requester 0:
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_ready`  out  1  requester 0 operand pair accepted this cycle when high with `req0_valid`.
- `req0_a`, `req0_b`  in  N each  requester 0 signed operands.

Requester 1:
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.

Responses:
- `resp0_valid`  out  1  product for requester 0 available.
- `resp0_ready`  in  1  requester 0 takes the product.
- `resp1_valid`, `resp1_ready`: same as requester 0, for requester 1.
- `resp_result`  out  2N  signed product. Shared bus, meaningful only when a `respX_valid` is high.

Multiplier side:
- `mult_a`, `mult_b`  out  N each  operands to `sync_smult`.
- `mult_result`  in  2N  `sync_smult` output, equal to the product of the operands presented on the previous cycle.

## Operation
- **Internal state:**
  - `prio`: 1 bit, the requester favoured on a tie.
  - `op_a`, `op_b`: last accepted operands.
  - `rv`: response-valid flag.
  - `rid`: 1 bit, owner of the pending response.
- **Response take:** `take = rv && (rid ? resp1_ready : resp0_ready)`.
- **Accept window:** `can_accept = !rv || take`. A pending response must be consumed before, or in the same cycle as, a new acceptance.
- **Grant:**
  - Only one requester valid: grant goes to it.
  - Both valid: grant goes to `prio`.
  - Neither valid: no grant.
- **Ready outputs:** `reqX_ready = can_accept && grant==X`. These are combinational from valid. At most one ready is high per cycle. A requester must hold valid and operands stable until it sees ready.
- **Accept** (ready && valid for the granted X) updates the following at the clock edge:
  - `op_a/op_b` <= granted operands.
  - `rid` <= X.
  - `rv` <= 1.
  - `prio` <= !X.
- **No accept:**
  - If `take`, `rv` <= 0.
  - Otherwise `rv`, `rid`, `op_*` and `prio` hold.
- **Multiplier drive:**
  - In an accept cycle, `mult_a/mult_b` = the granted requester's operands (combinational mux).
  - Otherwise, `mult_a/mult_b` = `op_a/op_b`.
  - Holding the operands during a stall keeps `mult_result` constant, so no result register is needed.
- **Response outputs:**
  - `resp_result = mult_result`, combinational passthrough.
  - `resp0_valid = rv && !rid`.
  - `resp1_valid = rv && rid`.
- **Arithmetic:** two's-complement N×N→2N, exact, no overflow or saturation. The product is fully sign-extended, e.g. 5 × -3 = 16'hFFF1 for N=8.
- **Ordering:** responses return in acceptance order. There is exactly one response per acceptance, and no response is ever dropped except by reset.

## Timing
- **Reset values** (while `rst` is high and on the first cycle after): `rv`=0, `rid`=0, `prio`=0, `op_a`=`op_b`=0. All outputs are therefore low or zero:
  - `req0_ready`, `req1_ready` = 0, forced low during reset.
  - `resp0_valid`, `resp1_valid` = 0.
  - `mult_a`, `mult_b` = 0, forced 0 during reset.
  - `resp_result` = `mult_result`, which is 0 from the first cycle after reset.

  The multiplier has no reset; driving zeros flushes it within one cycle.
- **Latency:** operands accepted in cycle c appear as a product with `respX_valid` high in cycle c+1.
- **Throughput:** back-to-back acceptances every cycle are allowed while the responder keeps `respX_ready` high. Alternating or single-requester streams are sustained at one per cycle.
- **Stall:** while `rv && !take`, both readys are low and `resp_result` and `respX_valid` are stable.
- **Simultaneous take and accept:** the old response completes and the new one appears the next cycle with no bubble.
- **Fairness:** with both requesters continuously valid, grants strictly alternate. Neither requester waits more than one accepted transaction.
- **Reset mid-operation:** any pending response is discarded, `prio` returns to requester 0, and no handshake completes in the reset cycle.

## Test plan
- **Single request:** `req0` a=5, b=4 accepted in cycle c → `resp0_valid`=1 and `resp_result`=20 in cycle c+1. `resp1_valid`=0 throughout.
- **Signed products:**
  - `req1` a=5, b=-3 → `resp_result`=16'hFFF1 (-15) on `resp1`.
  - a=-2, b=-3 → 6.
  - a=-128, b=-128 → 16'h4000.
  - a=-2, b=0 → 0.
- **Contention:** both requesters valid from reset with `req0`(3,3) and `req1`(2,7), responders always ready. Grants go `req0`, then `req1`, then `req0`… on consecutive cycles. Responses 9, 14, 9… alternate `resp0_valid`/`resp1_valid`.
- **Back-pressure:** `req0`(6,-7) accepted, then `resp0_ready`=0 for 3 cycles while `req1` is valid. Required behaviour:
  - `resp_result` holds -42 (16'hFFD6).
  - `req1_ready` stays 0.
  - In the cycle `resp0_ready` rises, `req1_ready`=1, and the `req1` product appears the next cycle.
- **Reset mid-flight:** `req0`(9,9) accepted and `rst` asserted in cycle c+1 with `resp0_ready`=0. Required response:
  - `resp0_valid`=0 from cycle c+2.
  - `mult_a`=`mult_b`=0 during reset.
  - With both requesters valid after reset, the first grant goes to `req0`.
